conv_rr_arbiter: RTL and testbench
==================================

Name: conv_rr_arbiter

Overview:
Round-robin arbiter that shares one streaming convolution engine between two requesters. The engine loads N samples, then emits L = N-M+1 results. The arbiter grants the engine to one requester for a whole job: all N x beats in, then all L y beats out. It routes both ready/valid streams, then releases the grant. It sits between two upstream x producers / downstream y consumers and a single conv engine instance.

Parameters:
N, 16, samples per job (x beats)
M, 4, filter length; sets L = N-M+1 y beats per job
T, 12, data width (signed)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
x_data0  in  T  requester 0 input sample
x_valid0  in  1  requester 0 sample valid
x_ready0  out  1  requester 0 sample accepted
y_data0  out  T  result to requester 0
y_valid0  out  1  result valid to requester 0
y_ready0  in  1  requester 0 result accepted
x_data1, x_valid1, x_ready1, y_data1, y_valid1, y_ready1  (same as above, requester 1)
e_x_data  out  T  sample to engine
e_x_valid  out  1  sample valid to engine
e_x_ready  in  1  engine accepts sample
e_y_data  in  T  engine result
e_y_valid  in  1  engine result valid
e_y_ready  out  1  result accepted by granted requester
grant  out  1  index of current owner (meaningful when busy=1)
busy  out  1  job in progress (state LOAD or DRAIN)
job_done  out  2  one-cycle pulse on requester's final y handshake; bit i = requester i

Behaviour:
- Async reset (reset=0) → state IDLE, x_cnt=0, y_cnt=0, grant=0, last=1 (requester 0 wins first tie), job_done=0.
- Outputs under reset: all ready/valid outputs 0.
- States: IDLE, LOAD, DRAIN.
- IDLE:
  - Request i = x_validi. No beat is accepted in IDLE; all ready/valid outputs are 0.
  - One request pending → grant it.
  - Both pending → grant !last.
  - On grant: register grant, go to LOAD, clear counters. Minimum one IDLE cycle between jobs.
- LOAD:
  - e_x_data = x_data[grant]; e_x_valid = x_valid[grant]; x_ready[grant] = e_x_ready. All combinational, no added latency.
  - Non-granted x_ready = 0.
  - Beat = e_x_valid & e_x_ready; x_cnt increments on each beat.
  - Beat with x_cnt==N-1 → DRAIN, x_cnt←0.
  - e_y_ready = 0 and y_valid* = 0 during LOAD; any engine y is held off.
- DRAIN:
  - y_data[grant] = e_y_data; y_valid[grant] = e_y_valid; e_y_ready = y_ready[grant].
  - All x_ready* = 0 and e_x_valid = 0.
  - y beat increments y_cnt.
  - Beat with y_cnt==L-1 → pulse job_done[grant] the next cycle (registered), last←grant, y_cnt←0, go IDLE.
- Non-granted y_valid is always 0. Its y_data mirrors e_y_data and is don't-care.
- Requester deasserting valid mid-job: the job stays granted; the arbiter waits indefinitely (no timeout, no preemption).
- Simultaneous last-y beat and a new request: the request is serviced from the following IDLE cycle; round-robin uses the updated last.
- Widths: x_cnt is $clog2(N+1) bits, y_cnt is $clog2(L+1) bits. Counters never wrap within a job.
- Reset mid-job: immediate return to IDLE. The engine has its own active-high reset and must be reset together with this block (system drives it from the same source, inverted); a partial job is discarded.
- busy = (state != IDLE). grant holds its value in IDLE.

Test Plan:
- Single job, N=16,M=4,T=12: req0 streams x=1..16 with constant valid, engine model f={28,4,-6,45}, y_ready0=1 → 16 x beats accepted, 13 y beats only on requester 0 with correct values, job_done=01 pulse once, busy falls, x_ready1/y_valid1 stay 0 throughout.
- Tie after reset: x_valid0=x_valid1=1 in the same cycle → grant=0 first; after its job_done, grant=1 (IDLE one cycle); the third job with both requesting → grant=0 again.
- Backpressure: random e_x_ready and y_ready0 toggling (~50%) → exactly 16 x and 13 y handshakes; no beat lost or duplicated; requester 1 never sees valid/ready.
- Upstream bubbles: x_valid0 drops for 5 cycles after beat 7 → state stays LOAD, x_cnt holds at 7, requester 1 (pending) is not granted until job 0 completes.
- Reset mid-DRAIN: assert reset=0 after 6 y beats → busy=0, all valid/ready outputs 0 immediately (async). After release, req1 pending → grant=1, x_cnt=0 on its first beat.
- Engine y early: engine asserts e_y_valid during LOAD → e_y_ready=0, y_valid0=0 until DRAIN entered.

Source files
------------

// File: rtl/conv_rr_arbiter_if.sv
// Stream bundle between the arbiter, its two requesters and the shared conv engine.
// The slave modport is the arbiter's view; master is the surrounding requesters plus engine.
interface conv_rr_arbiter_if #(
    parameter int unsigned T = 12
);
    // Requester 0
    logic signed [T-1:0] x_data0;
    logic                x_valid0;
    logic                x_ready0;
    logic signed [T-1:0] y_data0;
    logic                y_valid0;
    logic                y_ready0;
    // Requester 1
    logic signed [T-1:0] x_data1;
    logic                x_valid1;
    logic                x_ready1;
    logic signed [T-1:0] y_data1;
    logic                y_valid1;
    logic                y_ready1;
    // Engine side
    logic signed [T-1:0] e_x_data;
    logic                e_x_valid;
    logic                e_x_ready;
    logic signed [T-1:0] e_y_data;
    logic                e_y_valid;
    logic                e_y_ready;

    modport slave (
        input  x_data0, x_valid0, y_ready0,
        input  x_data1, x_valid1, y_ready1,
        input  e_x_ready, e_y_data, e_y_valid,
        output x_ready0, y_data0, y_valid0,
        output x_ready1, y_data1, y_valid1,
        output e_x_data, e_x_valid, e_y_ready
    );

    modport master (
        output x_data0, x_valid0, y_ready0,
        output x_data1, x_valid1, y_ready1,
        output e_x_ready, e_y_data, e_y_valid,
        input  x_ready0, y_data0, y_valid0,
        input  x_ready1, y_data1, y_valid1,
        input  e_x_data, e_x_valid, e_y_ready
    );
endinterface

// File: rtl/conv_rr_arbiter.sv
// Round-robin arbiter sharing one streaming convolution engine between two requesters.
// A grant covers a whole job: N x beats into the engine, then L = N-M+1 y beats back out.
module conv_rr_arbiter #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 4,
    parameter int unsigned T = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    conv_rr_arbiter_if.slave         bus,
    output logic                     grant,
    output logic                     busy,
    output logic [1:0]               job_done
);
    localparam int unsigned L  = N - M + 1;
    localparam int unsigned XW = $clog2(N + 1);
    localparam int unsigned YW = $clog2(L + 1);
    localparam logic [XW-1:0] XLast = XW'(N - 1);
    localparam logic [YW-1:0] YLast = YW'(L - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic [XW-1:0]   x_cnt_q, x_cnt_d;
    logic [YW-1:0]   y_cnt_q, y_cnt_d;
    logic [1:0]      job_done_q, job_done_d;

    logic signed [T-1:0] sel_x_data;
    logic                sel_x_valid;
    logic                sel_y_ready;
    logic                x_beat;
    logic                y_beat;

    // Select the granted requester's upstream signals and form the beat strobes.
    always_comb begin
        sel_x_data  = grant_q ? bus.x_data1  : bus.x_data0;
        sel_x_valid = grant_q ? bus.x_valid1 : bus.x_valid0;
        sel_y_ready = grant_q ? bus.y_ready1 : bus.y_ready0;
        x_beat      = (state_q == StLoad)  && sel_x_valid && bus.e_x_ready;
        y_beat      = (state_q == StDrain) && bus.e_y_valid && sel_y_ready;
    end

    // Stream routing: purely combinational, gated by phase so nothing leaks in IDLE.
    always_comb begin
        bus.e_x_data  = sel_x_data;
        bus.e_x_valid = 1'b0;
        bus.x_ready0  = 1'b0;
        bus.x_ready1  = 1'b0;
        bus.e_y_ready = 1'b0;
        bus.y_valid0  = 1'b0;
        bus.y_valid1  = 1'b0;
        // Non-granted y_data is don't-care, so both simply mirror the engine.
        bus.y_data0   = bus.e_y_data;
        bus.y_data1   = bus.e_y_data;
        unique case (state_q)
            StLoad: begin
                bus.e_x_valid = sel_x_valid;
                if (grant_q) bus.x_ready1 = bus.e_x_ready;
                else         bus.x_ready0 = bus.e_x_ready;
            end
            StDrain: begin
                bus.e_y_ready = sel_y_ready;
                if (grant_q) bus.y_valid1 = bus.e_y_valid;
                else         bus.y_valid0 = bus.e_y_valid;
            end
            default: ;
        endcase
    end

    // Next-state: arbitration in IDLE, beat counting in LOAD/DRAIN.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_d     = last_q;
        x_cnt_d    = x_cnt_q;
        y_cnt_d    = y_cnt_q;
        job_done_d = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (bus.x_valid0 || bus.x_valid1) begin
                    // On a tie the requester that did not own the last job wins.
                    if (bus.x_valid0 && bus.x_valid1) grant_d = ~last_q;
                    else                              grant_d = bus.x_valid1;
                    state_d = StLoad;
                    x_cnt_d = '0;
                    y_cnt_d = '0;
                end
            end
            StLoad: begin
                if (x_beat) begin
                    if (x_cnt_q == XLast) begin
                        x_cnt_d = '0;
                        state_d = StDrain;
                    end else begin
                        x_cnt_d = x_cnt_q + XW'(1);
                    end
                end
            end
            StDrain: begin
                if (y_beat) begin
                    if (y_cnt_q == YLast) begin
                        y_cnt_d             = '0;
                        job_done_d[grant_q] = 1'b1;
                        last_d              = grant_q;
                        state_d             = StIdle;
                    end else begin
                        y_cnt_d = y_cnt_q + YW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; async reset abandons any partial job.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= 1'b0;
            last_q     <= 1'b1;
            x_cnt_q    <= '0;
            y_cnt_q    <= '0;
            job_done_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            x_cnt_q    <= x_cnt_d;
            y_cnt_q    <= y_cnt_d;
            job_done_q <= job_done_d;
        end
    end

    // Status outputs.
    always_comb begin
        grant    = grant_q;
        busy     = (state_q != StIdle);
        job_done = job_done_q;
    end
endmodule

// File: tb/tb_conv_rr_arbiter.sv
// Bench for conv_rr_arbiter: two randomized requesters, a behavioural conv engine, and a
// reference that computes each job's results straight from the samples each requester sent.
module tb_conv_rr_arbiter;
    localparam int N    = 16;
    localparam int M    = 4;
    localparam int T    = 12;
    localparam int L    = N - M + 1;
    localparam int MaxS = 64;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       grant;
    logic       busy;
    logic [1:0] job_done;

    conv_rr_arbiter_if #(.T(T)) bus ();

    conv_rr_arbiter #(.N(N), .M(M), .T(T)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant    (grant),
        .busy     (busy),
        .job_done (job_done)
    );

    always #5 clk = ~clk;

    int F [M] = '{28, 4, -6, 45};

    // ---------------- engine model ----------------
    logic signed [T-1:0] eng_x [N];
    logic signed [T-1:0] eng_y [L];
    int                  eng_nx, eng_ny, eng_rd;
    logic                early_y;

    function automatic logic signed [T-1:0] eng_conv(int k, logic signed [T-1:0] lastx);
        int acc;
        int idx;
        logic signed [T-1:0] v;
        acc = 0;
        for (int j = 0; j < M; j++) begin
            idx = k + M - 1 - j;
            v   = (idx == N - 1) ? lastx : eng_x[idx];
            acc += F[j] * int'(v);
        end
        return T'(acc);
    endfunction

    assign bus.e_y_valid = (eng_rd < eng_ny) || early_y;
    assign bus.e_y_data  = (eng_rd < eng_ny) ? eng_y[eng_rd] : T'(2047);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_nx <= 0;
            eng_ny <= 0;
            eng_rd <= 0;
        end else begin
            if (bus.e_x_valid && bus.e_x_ready) begin
                eng_x[eng_nx] <= bus.e_x_data;
                if (eng_nx == N - 1) begin
                    for (int k = 0; k < L; k++) eng_y[k] <= eng_conv(k, bus.e_x_data);
                    eng_nx <= 0;
                    eng_ny <= L;
                    eng_rd <= 0;
                end else begin
                    eng_nx <= eng_nx + 1;
                end
            end
            if (bus.e_y_valid && bus.e_y_ready && eng_rd < eng_ny) eng_rd <= eng_rd + 1;
        end
    end

    // ---------------- requesters and reference ----------------
    logic signed [T-1:0] src0 [MaxS];
    logic signed [T-1:0] src1 [MaxS];
    int n0, n1, ptr0, ptr1;

    // Valid-convolution result k of a requester's job, from its own sample list.
    function automatic logic signed [T-1:0] ref_y(int req, int job, int k);
        int acc;
        logic signed [T-1:0] s;
        acc = 0;
        for (int j = 0; j < M; j++) begin
            s = (req == 0) ? src0[job * N + k + M - 1 - j] : src1[job * N + k + M - 1 - j];
            acc += F[j] * int'(s);
        end
        return T'(acc);
    endfunction

    logic signed [T-1:0] got0 [$];
    logic signed [T-1:0] got1 [$];
    int grant_log [$];

    int   checks, passes;
    int   cyc, p_xv, p_exr, p_yr0, p_yr1;
    int   hold_at, hold_len, hold_cnt, hold_viol;
    int   idle_viol, cross_viol, phase_viol;
    int   job_x, busy_rises, last_y_cyc, done_cyc, done0, done1;
    logic busy_prev;

    task automatic clear_sb();
        got0.delete();
        got1.delete();
        grant_log.delete();
        idle_viol  = 0; cross_viol = 0; phase_viol = 0; hold_viol = 0;
        job_x      = 0; busy_rises = 0; last_y_cyc = -100; done_cyc = -200;
        done0      = 0; done1      = 0; busy_prev  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b0;
        early_y      = 1'b0;
        bus.x_valid0 = 1'b0; bus.x_valid1 = 1'b0;
        bus.x_data0  = '0;   bus.x_data1  = '0;
        bus.y_ready0 = 1'b0; bus.y_ready1 = 1'b0;
        bus.e_x_ready = 1'b0;
        ptr0 = 0; ptr1 = 0; n0 = 0; n1 = 0;
        hold_at = -1; hold_len = 0; hold_cnt = 0;
        p_xv = 100; p_exr = 100; p_yr0 = 100; p_yr1 = 100;
        clear_sb();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    // One cycle: drive at negedge, observe 1ns later the handshakes that the next edge commits.
    task automatic step();
        logic hold;
        @(negedge clk);
        hold = (ptr0 == hold_at) && (hold_cnt < hold_len);
        if (hold) hold_cnt++;
        bus.x_valid0  = !hold && (ptr0 < n0) && (int'($urandom_range(99)) < p_xv);
        bus.x_data0   = (ptr0 < n0) ? src0[ptr0] : T'($urandom);
        bus.x_valid1  = (ptr1 < n1) && (int'($urandom_range(99)) < p_xv);
        bus.x_data1   = (ptr1 < n1) ? src1[ptr1] : T'($urandom);
        bus.y_ready0  = int'($urandom_range(99)) < p_yr0;
        bus.y_ready1  = int'($urandom_range(99)) < p_yr1;
        bus.e_x_ready = int'($urandom_range(99)) < p_exr;
        #1;
        cyc++;
        if (busy && !busy_prev) begin
            grant_log.push_back(int'(grant));
            busy_rises++;
            job_x = 0;
        end
        busy_prev = busy;
        if (!busy) begin
            if (bus.x_ready0 || bus.x_ready1 || bus.y_valid0 || bus.y_valid1 ||
                bus.e_x_valid || bus.e_y_ready) idle_viol++;
        end else begin
            if (grant == 1'b0 && (bus.x_ready1 || bus.y_valid1)) cross_viol++;
            if (grant == 1'b1 && (bus.x_ready0 || bus.y_valid0)) cross_viol++;
            if (job_x < N) begin
                if (bus.y_valid0 || bus.y_valid1 || bus.e_y_ready) phase_viol++;
            end else if (bus.x_ready0 || bus.x_ready1 || bus.e_x_valid) begin
                phase_viol++;
            end
        end
        if (hold && !(busy && grant == 1'b0)) hold_viol++;
        if (bus.x_valid0 && bus.x_ready0) begin ptr0++; job_x++; end
        if (bus.x_valid1 && bus.x_ready1) begin ptr1++; job_x++; end
        if (bus.y_valid0 && bus.y_ready0) begin got0.push_back(bus.y_data0); last_y_cyc = cyc; end
        if (bus.y_valid1 && bus.y_ready1) begin got1.push_back(bus.y_data1); last_y_cyc = cyc; end
        if (job_done[0]) begin done0++; done_cyc = cyc; end
        if (job_done[1]) begin done1++; done_cyc = cyc; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [5:0] outs;
        @(negedge clk);
        reset = 1'b0;
        bus.x_valid0 = 1'b1; bus.x_valid1 = 1'b1;
        bus.y_ready0 = 1'b1; bus.y_ready1 = 1'b1;
        bus.e_x_ready = 1'b1;
        early_y = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        outs = {bus.x_ready0, bus.x_ready1, bus.y_valid0, bus.y_valid1, bus.e_x_valid, bus.e_y_ready};
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++;
        if (grant !== 1'b0) $display("FAIL reset_grant: got %b expected 0", grant); else passes++;
        checks++;
        if (job_done !== 2'b00) $display("FAIL reset_job_done: got %b expected 00", job_done);
        else passes++;
        checks++;
        if (outs !== 6'b0) $display("FAIL reset_outputs: got %b expected 000000", outs);
        else passes++;
    endtask

    task automatic test_single_job();
        int bad;
        do_reset();
        n0 = N;
        for (int i = 0; i < N; i++) src0[i] = T'(i + 1);
        for (int c = 0; c < 300 && done0 < 1; c++) step();
        repeat (4) step();
        bad = 0;
        foreach (got0[i]) if (got0[i] !== ref_y(0, i / L, i % L)) bad++;
        checks++;
        if (ptr0 !== N) $display("FAIL single_x_beats: got %0d expected %0d", ptr0, N); else passes++;
        checks++;
        if (got0.size() !== L) $display("FAIL single_y_beats: got %0d expected %0d", got0.size(), L);
        else passes++;
        checks++;
        if (bad !== 0) $display("FAIL single_y_values: got %0d wrong expected 0", bad); else passes++;
        checks++;
        if (done0 !== 1 || done1 !== 0)
            $display("FAIL single_job_done: got %0d/%0d pulses expected 1/0", done0, done1);
        else passes++;
        checks++;
        if (done_cyc - last_y_cyc !== 1)
            $display("FAIL single_done_timing: got %0d cycles expected 1", done_cyc - last_y_cyc);
        else passes++;
        checks++;
        if (busy !== 1'b0 || busy_rises !== 1)
            $display("FAIL single_busy: got busy=%b rises=%0d expected 0/1", busy, busy_rises);
        else passes++;
        checks++;
        if (idle_viol + cross_viol + phase_viol !== 0)
            $display("FAIL single_routing: got %0d/%0d/%0d violations expected 0",
                     idle_viol, cross_viol, phase_viol);
        else passes++;
    endtask

    task automatic test_tie();
        int bad;
        int m_last;
        int m_g;
        do_reset();
        n0 = 2 * N; n1 = 2 * N;
        for (int i = 0; i < 2 * N; i++) begin
            src0[i] = T'($urandom);
            src1[i] = T'($urandom);
        end
        for (int c = 0; c < 600 && done0 + done1 < 3; c++) step();
        checks++;
        if (grant_log.size() !== 3) $display("FAIL tie_jobs: got %0d expected 3", grant_log.size());
        else passes++;
        // Both always pending: each job goes to whoever did not own the previous one.
        m_last = 1;
        for (int j = 0; j < 3 && j < grant_log.size(); j++) begin
            m_g = 1 - m_last;
            checks++;
            if (grant_log[j] !== m_g) $display("FAIL tie_grant%0d: got %0d expected %0d",
                                               j, grant_log[j], m_g);
            else passes++;
            m_last = m_g;
        end
        checks++;
        if (done0 !== 2 || done1 !== 1)
            $display("FAIL tie_done: got %0d/%0d expected 2/1", done0, done1);
        else passes++;
        bad = 0;
        foreach (got0[i]) if (got0[i] !== ref_y(0, i / L, i % L)) bad++;
        foreach (got1[i]) if (got1[i] !== ref_y(1, i / L, i % L)) bad++;
        checks++;
        if (bad !== 0 || got0.size() !== 2 * L || got1.size() !== L)
            $display("FAIL tie_y: got %0d wrong, sizes %0d/%0d expected 0, %0d/%0d",
                     bad, got0.size(), got1.size(), 2 * L, L);
        else passes++;
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        n0 = N;
        for (int i = 0; i < N; i++) src0[i] = T'($urandom);
        p_exr = 50; p_yr0 = 50;
        for (int c = 0; c < 2000 && done0 < 1; c++) step();
        repeat (3) step();
        bad = 0;
        foreach (got0[i]) if (got0[i] !== ref_y(0, i / L, i % L)) bad++;
        checks++;
        if (ptr0 !== N || done0 !== 1)
            $display("FAIL bp_x_beats: got %0d beats %0d done expected %0d/1", ptr0, done0, N);
        else passes++;
        checks++;
        if (got0.size() !== L || bad !== 0)
            $display("FAIL bp_y: got %0d beats %0d wrong expected %0d/0", got0.size(), bad, L);
        else passes++;
        checks++;
        if (cross_viol + idle_viol + phase_viol !== 0 || got1.size() !== 0)
            $display("FAIL bp_isolation: got %0d violations %0d y1 expected 0/0",
                     cross_viol + idle_viol + phase_viol, got1.size());
        else passes++;
    endtask

    task automatic test_bubbles();
        int bad;
        do_reset();
        n0 = N; n1 = N;
        for (int i = 0; i < N; i++) begin
            src0[i] = T'($urandom);
            src1[i] = T'($urandom);
        end
        hold_at = 7; hold_len = 5;
        for (int c = 0; c < 600 && done0 + done1 < 2; c++) step();
        checks++;
        if (hold_viol !== 0) $display("FAIL bubble_hold: got %0d bad cycles expected 0", hold_viol);
        else passes++;
        checks++;
        if (grant_log.size() !== 2 || grant_log[0] !== 0 || grant_log[1] !== 1)
            $display("FAIL bubble_order: got %0d jobs first=%0d expected 2 jobs 0 then 1",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        else passes++;
        bad = 0;
        foreach (got0[i]) if (got0[i] !== ref_y(0, i / L, i % L)) bad++;
        foreach (got1[i]) if (got1[i] !== ref_y(1, i / L, i % L)) bad++;
        checks++;
        if (bad !== 0 || got0.size() !== L || got1.size() !== L)
            $display("FAIL bubble_y: got %0d wrong sizes %0d/%0d expected 0 %0d/%0d",
                     bad, got0.size(), got1.size(), L, L);
        else passes++;
    endtask

    task automatic test_reset_drain();
        int bad;
        logic [5:0] outs;
        do_reset();
        n0 = N; n1 = N;
        for (int i = 0; i < N; i++) begin
            src0[i] = T'($urandom);
            src1[i] = T'($urandom);
        end
        for (int c = 0; c < 300 && got0.size() < 6; c++) step();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        outs = {bus.x_ready0, bus.x_ready1, bus.y_valid0, bus.y_valid1, bus.e_x_valid, bus.e_y_ready};
        checks++;
        if (busy !== 1'b0 || outs !== 6'b0)
            $display("FAIL rstdrain_async: got busy=%b outs=%b expected 0/000000", busy, outs);
        else passes++;
        repeat (2) step();
        @(negedge clk);
        reset = 1'b1;
        clear_sb();
        for (int c = 0; c < 300 && done1 < 1; c++) step();
        checks++;
        if (grant_log.size() !== 1 || grant_log[0] !== 1)
            $display("FAIL rstdrain_grant: got %0d jobs first=%0d expected 1 job grant 1",
                     grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
        else passes++;
        bad = 0;
        foreach (got1[i]) if (got1[i] !== ref_y(1, i / L, i % L)) bad++;
        checks++;
        if (ptr1 !== N || got1.size() !== L || bad !== 0 || got0.size() !== 0)
            $display("FAIL rstdrain_job1: got x=%0d y=%0d wrong=%0d y0=%0d expected %0d/%0d/0/0",
                     ptr1, got1.size(), bad, got0.size(), N, L);
        else passes++;
    endtask

    task automatic test_early_y();
        int bad;
        do_reset();
        early_y = 1'b1;
        n0 = N;
        for (int i = 0; i < N; i++) src0[i] = T'($urandom);
        p_exr = 30;
        for (int c = 0; c < 1000 && done0 < 1; c++) step();
        bad = 0;
        foreach (got0[i]) if (got0[i] !== ref_y(0, i / L, i % L)) bad++;
        checks++;
        if (phase_viol !== 0) $display("FAIL early_y_holdoff: got %0d leaks expected 0", phase_viol);
        else passes++;
        checks++;
        if (done0 !== 1 || got0.size() !== L || bad !== 0)
            $display("FAIL early_y_job: got done=%0d y=%0d wrong=%0d expected 1/%0d/0",
                     done0, got0.size(), bad, L);
        else passes++;
        early_y = 1'b0;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        cyc    = 0;
        early_y = 1'b0;
        clear_sb();
        test_reset();
        test_single_job();
        test_tie();
        test_backpressure();
        test_bubbles();
        test_reset_drain();
        test_early_y();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
